// File: rtl/axis_test_pkg.sv
// Shared definitions for the Stage-1 AXI-Stream loopback: test pattern defaults,
// checker FSM encodings, LFSR constants and a debug view of the checker.
package axis_test_pkg;

  localparam logic [31:0] DEFAULT_BASE    = 32'h1111_0000;
  localparam int          DEFAULT_N_WORDS = 32;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state[15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  typedef struct packed {
    state_t      state;
    logic [15:0] idx;
    logic [15:0] lfsr;
  } sink_dbg_t;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_test_sink_if.sv
// AXI-Stream bundle between the loopback path and the test sink.
interface axis_test_sink_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  // A beat transfers on a rising clk edge where tvalid & tready are both high;
  // a master holds tdata/tlast stable while tvalid is high and tready is low, and
  // tready never depends combinationally on tvalid.
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts toward the MSB with feedback into bit 0.
module axis_lfsr16
  import axis_test_pkg::*;
(
  input  logic        clk,
  input  logic        aresetn,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/axis_test_sink.sv
// Receive-side checker: verifies BASE+index payloads and frame length, keeps
// saturating frame/error counters and captures the first error seen.
module axis_test_sink
  import axis_test_pkg::*;
#(
  parameter int             W          = 32,
  parameter int             N_WORDS    = DEFAULT_N_WORDS,
  parameter logic [W-1:0]   BASE       = W'(DEFAULT_BASE),
  parameter int             READY_MODE = 0,
  parameter int             CNT_W      = 32
) (
  input  logic              clk,
  input  logic              aresetn,
  axis_test_sink_if.slave   s_axis,
  input  logic              clear,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  data_err_cnt,
  output logic [CNT_W-1:0]  len_err_cnt,
  output logic              err_sticky,
  output logic [15:0]       first_err_idx,
  output logic [W-1:0]      first_err_data,
  output logic              frame_done,
  output logic              frame_ok,
  output sink_dbg_t         dbg
);

  localparam int IDX_W = (CLOG2(N_WORDS) < 1) ? 1 : CLOG2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [15:0]       lfsr;
  logic              tready_q;
  logic              frame_err;
  logic              accept, data_err, len_err, close, close_ok, any_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  axis_lfsr16 u_lfsr (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (1'b1),
    .state   (lfsr)
  );

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid & tready_q;
  assign any_err       = data_err | len_err;
  assign dbg           = '{state: state, idx: 16'(idx), lfsr: lfsr};

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= ST_RUN;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    data_err = 1'b0;
    len_err  = 1'b0;
    close    = 1'b0;
    close_ok = 1'b0;
    if (accept) begin
      case (state)
        ST_RUN: begin
          data_err = (s_axis.tdata != (BASE + W'(idx)));
          if (s_axis.tlast) begin
            close   = 1'b1;
            len_err = (idx != LAST_IDX);
            idx_nx  = '0;
          end else if (idx == LAST_IDX) begin
            len_err  = 1'b1;
            state_nx = ST_DROP;
          end else begin
            idx_nx = idx + 1'b1;
          end
          // A coincident clear discards this frame's error history
          close_ok = clear | ~(frame_err | data_err | len_err);
        end
        ST_DROP: begin
          if (s_axis.tlast) begin
            close    = 1'b1;
            idx_nx   = '0;
            state_nx = ST_RUN;
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tready_q       <= 1'b0;
      frame_cnt      <= '0;
      data_err_cnt   <= '0;
      len_err_cnt    <= '0;
      err_sticky     <= 1'b0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      frame_done     <= 1'b0;
      frame_ok       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      tready_q   <= (READY_MODE == 1) ? lfsr[0] : 1'b1;
      frame_done <= close;
      frame_ok   <= close & close_ok;
      if (clear) begin
        frame_cnt      <= '0;
        data_err_cnt   <= '0;
        len_err_cnt    <= '0;
        err_sticky     <= 1'b0;
        first_err_idx  <= '0;
        first_err_data <= '0;
        frame_err      <= 1'b0;
      end else begin
        if (close)    frame_cnt    <= sat_inc(frame_cnt);
        if (data_err) data_err_cnt <= sat_inc(data_err_cnt);
        if (len_err)  len_err_cnt  <= sat_inc(len_err_cnt);
        if (any_err && !err_sticky) begin
          err_sticky     <= 1'b1;
          first_err_idx  <= 16'(idx);
          first_err_data <= s_axis.tdata;
        end
        if (close)        frame_err <= 1'b0;
        else if (any_err) frame_err <= 1'b1;
      end
    end
  end

endmodule
